// File: rtl/cast_vc_allocator.sv
// cast_vc_allocator
// Shared output-channel allocator for one cast router. Each head flit's
// request vector is granted all-or-nothing, so a multicast packet never
// holds a partial set of outputs. A granted output stays owned by its
// input until that input's tail flit fires.
//
// Ports:
//   clk        router clock
//   rstn       asynchronous, active-low reset
//   req        request vector of input i at [i*NP +: NP] (multi-hot allowed)
//   tail_fire  input i's tail flit transferred this cycle
//   sel_out    granted output vector of input i (req slice when granted, else 0)
//   granted    input i granted this cycle (combinational, from registered state)
//   out_busy   output o currently owned
//   out_owner  owner index of output o at [o*OW +: OW] (valid when out_busy[o])
//
// Configuration macro:
//   CAST_VCA_RR_EN  defined   -> rotating priority pointer (starvation-free)
//                   undefined -> fixed priority, input 0 highest, no pointer register
module cast_vc_allocator #(
    parameter int NP = 5,
    parameter int OW = $clog2(NP)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [NP*NP-1:0] req,
    input  logic [NP-1:0]    tail_fire,
    output logic [NP*NP-1:0] sel_out,
    output logic [NP-1:0]    granted,
    output logic [NP-1:0]    out_busy,
    output logic [NP*OW-1:0] out_owner
);

    logic [NP-1:0] busy_reg;
    logic [NP-1:0] busy_next;
    logic [NP-1:0] hold_reg;
    logic [NP-1:0] hold_next;
    logic [OW-1:0] owner_reg  [NP];
    logic [OW-1:0] owner_next [NP];
    logic [NP-1:0] grant_raw;
    logic [OW-1:0] rr;

`ifdef CAST_VCA_RR_EN
    logic [OW-1:0] rr_reg;
    logic [OW-1:0] rr_next;

    // Pointer moves just past the highest-priority winner of this cycle.
    always_comb begin
        int idx;
        logic found;
        rr_next = rr_reg;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NP; k++) begin
            idx = int'(rr_reg) + k;
            if (idx >= NP) idx = idx - NP;
            if (!found && grant_raw[idx]) begin
                found   = 1'b1;
                rr_next = (idx == NP - 1) ? '0 : OW'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rr_reg <= '0;
        else       rr_reg <= rr_next;
    end

    assign rr = rr_reg;
`else
    assign rr = '0;
`endif

    // Priority scan from rr. An input is eligible only when every output it
    // asks for is free in registered state and not already claimed by a
    // higher-priority winner this cycle; this keeps multicast atomic.
    always_comb begin
        logic [NP-1:0] claimed;
        logic [NP-1:0] slice;
        int idx;
        claimed   = '0;
        slice     = '0;
        grant_raw = '0;
        idx       = 0;
        for (int k = 0; k < NP; k++) begin
            idx = int'(rr) + k;
            if (idx >= NP) idx = idx - NP;
            slice = req[idx*NP +: NP];
            if ((slice != '0) && !hold_reg[idx] &&
                ((slice & busy_reg) == '0) && ((slice & claimed) == '0)) begin
                grant_raw[idx] = 1'b1;
                claimed        = claimed | slice;
            end
        end
    end

    // Release is evaluated on registered ownership, so a freed output only
    // becomes grantable in the cycle after tail_fire. A tail on an input
    // being granted in the same cycle cancels the grant's ownership.
    always_comb begin
        busy_next = busy_reg;
        hold_next = hold_reg;
        for (int o = 0; o < NP; o++) begin
            owner_next[o] = owner_reg[o];
            if (busy_reg[o] && tail_fire[owner_reg[o]] && hold_reg[owner_reg[o]])
                busy_next[o] = 1'b0;
        end
        for (int i = 0; i < NP; i++) begin
            if (tail_fire[i]) begin
                hold_next[i] = 1'b0;
            end else if (grant_raw[i]) begin
                hold_next[i] = 1'b1;
                for (int o = 0; o < NP; o++) begin
                    if (req[i*NP + o]) begin
                        busy_next[o]  = 1'b1;
                        owner_next[o] = OW'(i);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_reg <= '0;
            hold_reg <= '0;
            for (int o = 0; o < NP; o++) owner_reg[o] <= '0;
        end else begin
            busy_reg <= busy_next;
            hold_reg <= hold_next;
            for (int o = 0; o < NP; o++) owner_reg[o] <= owner_next[o];
        end
    end

    // Grants are forced low while reset is asserted.
    assign granted  = grant_raw & {NP{rstn}};
    assign out_busy = busy_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NP; gi++) begin : g_port
            assign sel_out[gi*NP +: NP]   = granted[gi] ? req[gi*NP +: NP] : '0;
            assign out_owner[gi*OW +: OW] = owner_reg[gi];
        end
    endgenerate

    // A tail and a grant on the same input in one cycle means the controller
    // sent a tail before it ever owned anything.
    a_tail_vs_grant: assert property (@(posedge clk) disable iff (!rstn)
        (tail_fire & grant_raw) == '0);

endmodule

// File: tb/tb_cast_vc_allocator.sv
// Self-checking bench for cast_vc_allocator (NP=5): an ownership-map model
// checked every cycle, plus hand-computed literal expectations.
module tb_cast_vc_allocator;
    localparam int NP = 5;
    localparam int OW = 3;
`ifdef CAST_VCA_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [NP*NP-1:0] req = '0;
    logic [NP-1:0]    tail_fire = '0;
    logic [NP*NP-1:0] sel_out;
    logic [NP-1:0]    granted;
    logic [NP-1:0]    out_busy;
    logic [NP*OW-1:0] out_owner;

    int checks = 0;
    int fails  = 0;

    cast_vc_allocator #(.NP(NP), .OW(OW)) dut (
        .clk(clk), .rstn(rstn), .req(req), .tail_fire(tail_fire),
        .sel_out(sel_out), .granted(granted), .out_busy(out_busy),
        .out_owner(out_owner)
    );

    always #5 clk = ~clk;

    // ---------------- model: owner of each output (-1 = free) ----------------
    int own [NP];
    int m_rr;

    function automatic logic [NP-1:0] model_grant(input logic [NP*NP-1:0] r);
        logic [NP-1:0] g, claimed, s;
        bit held, free;
        int idx;
        g = '0;
        claimed = '0;
        for (int k = 0; k < NP; k++) begin
            idx = (m_rr + k) % NP;
            s = r[idx*NP +: NP];
            held = 0;
            free = 1;
            for (int o = 0; o < NP; o++) begin
                if (own[o] == idx) held = 1;
                if (s[o] && own[o] >= 0) free = 0;
            end
            if (s != '0 && !held && free && (s & claimed) == '0) begin
                g[idx] = 1'b1;
                claimed = claimed | s;
            end
        end
        return g;
    endfunction

    task automatic model_reset();
        for (int o = 0; o < NP; o++) own[o] = -1;
        m_rr = 0;
    endtask

    initial model_reset();
    always @(negedge rstn) model_reset();

    always @(posedge clk) begin
        logic [NP-1:0] g;
        bit found;
        if (!rstn) begin
            model_reset();
        end else begin
            g = model_grant(req);
            for (int o = 0; o < NP; o++)
                if (own[o] >= 0 && tail_fire[own[o]]) own[o] = -1;
            for (int i = 0; i < NP; i++)
                if (g[i] && !tail_fire[i])
                    for (int o = 0; o < NP; o++)
                        if (req[i*NP + o]) own[o] = i;
            if (RR && g != '0) begin
                found = 0;
                for (int k = 0; k < NP; k++)
                    if (!found && g[(m_rr + k) % NP]) begin
                        found = 1;
                        m_rr = ((m_rr + k) % NP + 1) % NP;
                    end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [NP-1:0] eg, eb;
        logic [NP*NP-1:0] es;
        if (rstn) begin
            eg = model_grant(req);
            es = '0;
            eb = '0;
            for (int i = 0; i < NP; i++)
                if (eg[i]) es[i*NP +: NP] = req[i*NP +: NP];
            for (int o = 0; o < NP; o++) eb[o] = (own[o] >= 0);
            chk("cmp_granted", 32'(granted), 32'(eg));
            chk("cmp_sel_out", 32'(sel_out), 32'(es));
            chk("cmp_out_busy", 32'(out_busy), 32'(eb));
            for (int o = 0; o < NP; o++)
                if (own[o] >= 0)
                    chk("cmp_out_owner", 32'(out_owner[o*OW +: OW]), 32'(own[o]));
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [NP*NP-1:0] rq(input int i, input logic [NP-1:0] v);
        logic [NP*NP-1:0] r;
        r = '0;
        r[i*NP +: NP] = v;
        return r;
    endfunction

    task automatic drive(input logic [NP*NP-1:0] r, input logic [NP-1:0] tf);
        @(posedge clk);
        #1;
        req = r;
        tail_fire = tf;
        #1;
    endtask

    initial begin
        logic [NP-1:0] expw;
        // Reset state, with a request present to show grants are masked.
        req = rq(0, 5'b00001);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(out_busy), 32'h0);
        chk("rst_granted", 32'(granted), 32'h0);
        chk("rst_owner", 32'(out_owner), 32'h0);
        rstn = 1'b1;
        req = '0;

        // Unicast, no contention.
        drive(rq(2, 5'b00100), '0);
        chk("uni_granted", 32'(granted), 32'h04);
        chk("uni_sel", 32'(sel_out), 32'(rq(2, 5'b00100)));
        drive('0, '0);
        chk("uni_busy", 32'(out_busy), 32'h04);
        chk("uni_owner", 32'(out_owner[2*OW +: OW]), 32'd2);
        drive('0, 5'b00100);
        chk("uni_busy_tail", 32'(out_busy), 32'h04);
        drive('0, '0);
        chk("uni_freed", 32'(out_busy), 32'h0);

        // Multicast atomicity; held input re-requesting is ignored.
        drive(rq(1, 5'b01000), '0);
        chk("mc_own_grant", 32'(granted), 32'h02);
        drive(rq(0, 5'b01010), '0);
        chk("mc_blocked", 32'(granted), 32'h0);
        drive(rq(0, 5'b01010) | rq(1, 5'b00001), '0);
        chk("held_ignored", 32'(granted), 32'h0);
        drive(rq(0, 5'b01010), 5'b00010);
        chk("mc_release_cycle", 32'(granted), 32'h0);
        drive(rq(0, 5'b01010), '0);
        chk("mc_granted", 32'(granted), 32'h01);
        chk("mc_sel", 32'(sel_out), 32'(rq(0, 5'b01010)));
        drive('0, '0);
        chk("mc_busy", 32'(out_busy), 32'h0a);
        drive('0, 5'b00001);
        drive('0, '0);
        chk("mc_freed", 32'(out_busy), 32'h0);

        // Stray tail_fire on an input that owns nothing.
        drive(rq(4, 5'b10000), '0);
        chk("stray_grant", 32'(granted), 32'h10);
        drive('0, 5'b00100);
        drive('0, '0);
        chk("stray_busy", 32'(out_busy), 32'h10);
        chk("stray_owner", 32'(out_owner[4*OW +: OW]), 32'd4);
        drive('0, 5'b10000);
        drive('0, '0);

        // Same-cycle contention on output 0; rr starts at 0 here.
        for (int r = 0; r < 4; r++) begin
            expw = (RR && (r % 2 == 1)) ? 5'b10000 : 5'b00001;
            drive(rq(0, 5'b00001) | rq(4, 5'b00001), '0);
            chk("cont_winner", 32'(granted), 32'(expw));
            drive(rq(0, 5'b00001) | rq(4, 5'b00001), expw);
            chk("cont_hold", 32'(granted), 32'h0);
        end
        drive('0, '0);

        // Disjoint parallel grants.
        drive(rq(1, 5'b00011) | rq(3, 5'b01100), '0);
        chk("par_granted", 32'(granted), 32'h0a);
        drive('0, '0);
        chk("par_busy", 32'(out_busy), 32'h0f);
        drive('0, 5'b01010);
        drive('0, '0);
        chk("par_freed", 32'(out_busy), 32'h0);

        // Reset mid-packet with outputs 1 and 4 busy.
        drive(rq(1, 5'b10010), '0);
        chk("rm_grant", 32'(granted), 32'h02);
        drive(rq(2, 5'b00001), '0);
        chk("rm_busy", 32'(out_busy), 32'h12);
        chk("rm_pre_grant", 32'(granted), 32'h04);
        rstn = 1'b0;
        #1;
        chk("rm_async_busy", 32'(out_busy), 32'h0);
        chk("rm_async_granted", 32'(granted), 32'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        req = rq(0, 5'b00100) | rq(3, 5'b00100);
        #1;
        chk("rm_rr_zero", 32'(granted), 32'h01);
        drive('0, '0);
        chk("rm_owner", 32'(out_owner[2*OW +: OW]), 32'd0);
        drive('0, 5'b00001);
        drive('0, '0);
        chk("end_busy", 32'(out_busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/cast_vc_allocator.md
# cast_vc_allocator

Shared output-channel allocator for one cast router. It arbitrates the `CN` output channels among the `CN` input controllers and grants each head flit's full request vector all-or-nothing, so multicast packets never hold a partial set of outputs. Each granted output stays owned by its input until that input's tail flit fires. It sits between the per-port input controllers (reqVC / selOutVC / VCgranted) and the crossbar select logic.

## Interface
- NP, default `CN` (5): number of input ports, equal to the number of output channels.
- OW, default $clog2(NP): width of an owner index.
- clk  input  1  router clock.
- rstn  input  1  reset, asynchronous, active-low.
- req  input  NP*NP  request vector of input i at [i*NP +: NP], bit o = output o wanted; multi-hot allowed.
- tail_fire  input  NP  input i's tail flit transferred this cycle.
- sel_out  output  NP*NP  granted output vector for input i at [i*NP +: NP]; equals req slice when granted, else 0.
- granted  output  NP  input i granted this cycle.
- out_busy  output  NP  output o currently owned (registered).
- out_owner  output  NP*OW  owner index of output o (valid when out_busy[o]).

## Operation
- Per-output state: FREE or BUSY(owner). Per-input hold flag hold[i] is set while input i owns at least one output.
- Eligibility of input i: req slice nonzero, hold[i]=0, and every requested output FREE in the registered state.
- Arbitration: scan the inputs in priority order starting at pointer rr. Grant an eligible input only if none of its requested outputs was already claimed by a higher-priority input granted in the same cycle. Several disjoint inputs may be granted in one cycle.
- On a grant, at the next clk edge:
  - each requested output goes BUSY with owner i;
  - hold[i] is set.
- Release: tail_fire[i] with hold[i]=1 frees every output owned by i and clears hold[i] at the next edge. tail_fire[i] with hold[i]=0 is ignored.
- Freed outputs are not visible to arbitration in the release cycle. They are grantable in the following cycle.
- A request from an input with hold[i]=1 is ignored: no grant and no error.
- Simultaneous tail_fire[i] and granted[i]: the release wins. No ownership is recorded. A simulation assertion fires.
- A zero request vector is never granted.
- Reset (any time, including mid-packet): all outputs FREE, hold=0, rr=0, granted=0, sel_out=0, out_busy=0, out_owner=0.

## Timing
- Grant is combinational. granted and sel_out are valid in the same cycle as req, computed from registered state only, so there is no path from req to state.
- out_busy / out_owner update one cycle after a grant and one cycle after tail_fire.
- Minimum reuse gap for one output: tail_fire in cycle t, free at t+1, re-grantable at t+1 (visible state), owned again at t+2.
- Requesters hold req until granted. The allocator keeps no memory of an ungranted request.
- rr updates at the edge after any grant cycle, to (index of the highest-priority winner + 1) mod NP. It is unchanged in cycles with no grant.

## Configuration
- CAST_VCA_RR_EN defined: rotating priority pointer rr as described, which gives starvation-free service among contending inputs.
- CAST_VCA_RR_EN undefined: rr is held at 0, giving fixed priority with input 0 highest. No pointer register is synthesised. All other behaviour is identical.

## Test plan
- Unicast, no contention: input 2 req=5'b00100 → granted[2]=1 and sel_out slice=00100 in the same cycle; out_busy[2]=1 and owner=2 next cycle. tail_fire[2] → out_busy[2]=0 the following cycle.
- Multicast atomicity: output 3 owned by input 1; input 0 req=5'b01010 → no grant while out 3 is busy. Input 1 tail_fire → input 0 granted 01010 one cycle after the release edge, never 00010 alone.
- Same-cycle contention (RR_EN): inputs 0 and 4 both req 5'b00001 repeatedly, each releasing one cycle after its grant → grants alternate 0,4,0,4. Without RR_EN → always 0 while 0 re-requests.
- Disjoint parallel grants: input 1 req 00011 and input 3 req 01100 in the same cycle → both granted in that cycle; out_busy=01111 next cycle.
- Boundaries:
  - tail_fire[2] with no ownership → no state change;
  - req from an input already holding outputs → ignored;
  - tail_fire and grant on the same input in the same cycle → no ownership recorded, assertion fires.
- Reset mid-packet: assert rstn=0 while outputs 1 and 4 are BUSY → out_busy=0, granted=0 immediately (asynchronous); after release of reset the first request is arbitrated from rr=0.
